// File: rtl/seqdet_pkg.sv
// Shared types and constants for the sequence detector and its stimulus serializer.
// The serializer's optional parity bit is controlled by the SEQDET_SER_PARITY_EN macro.
package seqdet_pkg;

    localparam int SEQDET_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_GAP    = 2'd3
    } seqdet_ser_state_e;

endpackage

// File: rtl/seqdet_stim_serializer_if.sv
// Word handshake plus serial output bundle between a stimulus source and the serializer.
// The master side supplies words and watches the serial line; the slave side is the serializer.
interface seqdet_stim_serializer_if
    import seqdet_pkg::*;
#(
    parameter int WIDTH = SEQDET_WIDTH
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             t;
    logic             t_valid;
    logic             busy;
    logic             word_done;

    modport master (
        output in_data, in_valid,
        input  in_ready, t, t_valid, busy, word_done
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, t, t_valid, busy, word_done
    );
endinterface

// File: rtl/seqdet_bit_timer.sv
// Bit-period prescaler: counts 0..BIT_CYCLES-1 and flags the final clock of each bit.
// bit_end_o describes the current clock, bit_end_next_o the clock after the coming edge,
// which lets the parent register outputs that must line up with the last clock of a bit.
module seqdet_bit_timer
    import seqdet_pkg::*;
#(
    parameter int BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic bit_end_o,
    output logic bit_end_next_o
);
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: a load restarts the bit, otherwise wrap at the end of each bit period.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    // Count register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bit_end_o      = (count_q == LAST);
    assign bit_end_next_o = (count_d == LAST);
endmodule

// File: rtl/seqdet_stim_serializer.sv
// Parallel-to-serial stimulus stage feeding the Moore sequence detector, MSB first.
// Define SEQDET_SER_PARITY_EN to append an even parity bit after bit 0 of every word.
module seqdet_stim_serializer
    import seqdet_pkg::*;
#(
    parameter int WIDTH      = SEQDET_WIDTH,
    parameter int BIT_CYCLES = 1,
    parameter int GAP        = 0
) (
    input  logic clk,
    input  logic rst_n,
    seqdet_stim_serializer_if.slave bus
);
    localparam int IW = $clog2(WIDTH);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;
    localparam logic [IW-1:0] IDX_MSB  = IW'(WIDTH - 1);

    seqdet_ser_state_e state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              t_q, t_d;
    logic              t_valid_q, t_valid_d;
    logic              busy_q, busy_d;
    logic              word_done_q, word_done_d;

    logic bit_end;
    logic bit_end_next;
    logic last_final;
    logic ready;
    logic xfer;

    seqdet_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear_i        (xfer),
        .en_i           (state_q != S_IDLE),
        .bit_end_o      (bit_end),
        .bit_end_next_o (bit_end_next)
    );

`ifdef SEQDET_SER_PARITY_EN
    assign last_final = bit_end && (state_q == S_PARITY);
`else
    assign last_final = bit_end && (state_q == S_SHIFT) && (idx_q == '0);
`endif

    // With no gap the source may hand over the next word in the last clock of the current one.
    assign ready = rst_n && ((state_q == S_IDLE) || ((GAP == 0) && last_final));
    assign xfer  = bus.in_valid && ready;

    // Next-state and next-output decode; outputs are computed from next values so they register cleanly.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        t_d         = 1'b0;
        t_valid_d   = 1'b0;
        word_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_SHIFT: begin
                if (bit_end) begin
                    if (idx_q != '0) begin
                        idx_d = idx_q - 1'b1;
                    end else begin
`ifdef SEQDET_SER_PARITY_EN
                        state_d = S_PARITY;
`else
                        if (GAP > 0) begin
                            state_d = S_GAP;
                            gap_d   = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
`endif
                    end
                end
            end
`ifdef SEQDET_SER_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    if (GAP > 0) begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            S_GAP: begin
                if (bit_end) begin
                    if (gap_q == GAP_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (xfer) begin
            state_d = S_SHIFT;
            shreg_d = bus.in_data;
            idx_d   = IDX_MSB;
        end

        case (state_d)
            S_SHIFT: begin
                t_d       = shreg_d[idx_d];
                t_valid_d = 1'b1;
            end
`ifdef SEQDET_SER_PARITY_EN
            S_PARITY: begin
                t_d       = ^shreg_d;
                t_valid_d = 1'b1;
            end
`endif
            default: begin
                t_d       = 1'b0;
                t_valid_d = 1'b0;
            end
        endcase

`ifdef SEQDET_SER_PARITY_EN
        word_done_d = bit_end_next && (state_d == S_PARITY);
`else
        word_done_d = bit_end_next && (state_d == S_SHIFT) && (idx_d == '0);
`endif
    end

    assign busy_d = (state_d != S_IDLE);

    // State, datapath and registered outputs with synchronous active-low reset aborting any word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            idx_q       <= '0;
            gap_q       <= '0;
            t_q         <= 1'b0;
            t_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            t_q         <= t_d;
            t_valid_q   <= t_valid_d;
            busy_q      <= busy_d;
            word_done_q <= word_done_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.t         = t_q;
    assign bus.t_valid   = t_valid_q;
    assign bus.busy      = busy_q;
    assign bus.word_done = word_done_q;
endmodule
